list_builder: RTL and testbench

//  Writer end of the linked-list next-table. Accepts a stream of node pointers

---
 rtl/list_builder_if.sv | 29 ++
 rtl/list_builder.sv | 141 ++++++++++++++
 tb/tb_list_builder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/list_builder_if.sv
// Handshake bundle between the node-pointer producer, the next-table writer and
// the head consumer.
interface list_builder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_ptr;
    logic             in_last;
    logic             in_vld;
    logic             in_rdy;
    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] head_ptr;
    logic             head_vld;
    logic             head_rdy;
    logic             err_null;
    logic             err_dup;

    modport slave (
        input  in_ptr, in_last, in_vld, clr, head_rdy,
        output in_rdy, wr_en, wr_addr, wr_data, head_ptr, head_vld, err_null, err_dup
    );

    modport master (
        output in_ptr, in_last, in_vld, clr, head_rdy,
        input  in_rdy, wr_en, wr_addr, wr_data, head_ptr, head_vld, err_null, err_dup
    );
endinterface

// File: rtl/list_builder.sv
// Writer end of the linked-list next-table: links accepted nodes tail-to-node,
// terminates each list with a null write and queues list heads in a small FIFO.
module list_builder #(
    parameter int N          = 16,
    parameter int WIDTH      = $clog2(N),
    parameter int HEAD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    list_builder_if.slave bus
);
    localparam int PW = (HEAD_DEPTH > 1) ? $clog2(HEAD_DEPTH) : 1;
    localparam int CW = $clog2(HEAD_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        TERM
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] tail_q;
    logic [N-1:0]     used_q;
    logic             wr_en_q;
    logic [WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             err_null_q;
    logic             err_dup_q;

    logic [WIDTH-1:0] fifo_mem [HEAD_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic fifo_space;
    logic accept;
    logic is_null;
    logic is_used;
    logic good;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(HEAD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO blocks a new list even if a pop happens in the same cycle.
    assign fifo_space = (count_q < CW'(HEAD_DEPTH));
    assign bus.in_rdy = ~bus.clr & ((state_q == OPEN) | ((state_q == IDLE) & fifo_space));
    assign accept     = bus.in_vld & bus.in_rdy;
    assign is_null    = (bus.in_ptr == '0);
    assign is_used    = used_q[bus.in_ptr];
    assign good       = accept & ~is_null & ~is_used;
    assign push       = good & (state_q == IDLE);
    assign pop        = bus.head_vld & bus.head_rdy;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; head_vld masks stale entries.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.in_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tail_q     <= '0;
            used_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_null_q <= 1'b0;
            err_dup_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_en_q    <= 1'b0;
            err_null_q <= accept & is_null;
            err_dup_q  <= accept & ~is_null & is_used;
            case (state_q)
                IDLE: begin
                    if (bus.clr) used_q <= '0;
                    if (good) begin
                        used_q[bus.in_ptr] <= 1'b1;
                        tail_q             <= bus.in_ptr;
                        state_q            <= bus.in_last ? TERM : OPEN;
                    end
                end
                OPEN: begin
                    if (good) begin
                        wr_en_q            <= 1'b1;
                        wr_addr_q          <= tail_q;
                        wr_data_q          <= bus.in_ptr;
                        used_q[bus.in_ptr] <= 1'b1;
                        tail_q             <= bus.in_ptr;
                    end
                    // A dropped last node still closes the list at the old tail.
                    if (accept && bus.in_last) state_q <= TERM;
                end
                TERM: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= tail_q;
                    wr_data_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.err_null = err_null_q;
    assign bus.err_dup  = err_dup_q;
    assign bus.head_vld = (count_q != '0);
    assign bus.head_ptr = bus.head_vld ? fifo_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_list_builder.sv
// Scoreboard bench for list_builder: a list-level reference model predicts writes,
// heads and error pulses; a monitor compares them as the DUT presents them.
module tb_list_builder;
    localparam int N = 16;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   hr  = 1'b1;

    int checks = 0;
    int errors = 0;

    wr_t wq[$];
    int  hq[$];
    int  eq[$];
    bit  used_m[N];
    bit  open_m    = 1'b0;
    bit  closing_m = 1'b0;
    int  tail_m    = 0;

    always #5 clk = ~clk;

    list_builder_if #(.WIDTH(W)) bus ();

    list_builder #(.N(N), .WIDTH(W), .HEAD_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        open_m    = 1'b0;
        closing_m = 1'b0;
        tail_m    = 0;
        foreach (used_m[i]) used_m[i] = 1'b0;
        wq.delete();
        hq.delete();
        eq.delete();
    endfunction

    // List-level semantics: first good node is the head, each later good node links
    // from the previous one, and the close links the last good node to null.
    function automatic void model_accept(input int ptr, input bit last);
        if (ptr == 0) eq.push_back(1);
        else if (used_m[ptr]) eq.push_back(2);
        else begin
            used_m[ptr] = 1'b1;
            if (!open_m) hq.push_back(ptr);
            else wq.push_back('{addr: tail_m, data: ptr});
            tail_m = ptr;
            open_m = 1'b1;
        end
        if (last && open_m) begin
            wq.push_back('{addr: tail_m, data: 0});
            open_m    = 1'b0;
            closing_m = 1'b1;
        end
    endfunction

    task automatic cycle(input bit vld, input int ptr, input bit last, input bit c, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        bus.in_vld   = vld;
        bus.in_ptr   = W'(ptr);
        bus.in_last  = last;
        bus.clr      = c;
        bus.head_rdy = hr;
        #1;
        exp_rdy = !c && !closing_m && (open_m || hq.size() < D);
        check("in_rdy", bus.in_rdy, exp_rdy);
        acc = vld && bus.in_rdy;
        if (closing_m) closing_m = 1'b0;
        else if (c && !open_m) foreach (used_m[i]) used_m[i] = 1'b0;
        if (acc) model_accept(ptr, last);
    endtask

    task automatic idle(input bit c = 1'b0);
        bit acc;
        cycle(1'b0, 0, 1'b0, c, acc);
    endtask

    task automatic send(input int ptr, input bit last);
        bit acc;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, ptr, last, 1'b0, acc);
            if (acc) return;
        end
        check("send_timeout", 0, 1);
    endtask

    initial begin : monitor
        wr_t w;
        int  e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.wr_en) begin
                if (wq.size() == 0) check("wr_unexpected", {bus.wr_addr, bus.wr_data}, 0);
                else begin
                    w = wq.pop_front();
                    check("wr_pair", {bus.wr_addr, bus.wr_data}, {W'(w.addr), W'(w.data)});
                end
            end
            if (bus.err_null || bus.err_dup) begin
                if (eq.size() == 0) check("err_unexpected", {bus.err_dup, bus.err_null}, 0);
                else begin
                    e = eq.pop_front();
                    check("err_kind", {bus.err_dup, bus.err_null}, (e == 1) ? 2'b01 : 2'b10);
                end
            end
            if (bus.head_vld && bus.head_rdy) begin
                if (hq.size() == 0) check("head_unexpected", bus.head_ptr, 0);
                else check("head_ptr", bus.head_ptr, hq.pop_front());
            end
        end
    end

    initial begin : stim
        bit acc;
        bus.in_vld   = 1'b0;
        bus.in_ptr   = '0;
        bus.in_last  = 1'b0;
        bus.clr      = 1'b0;
        bus.head_rdy = 1'b1;
        model_reset();
        #12;
        check("rst_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.head_vld,
                              bus.head_ptr, bus.err_null, bus.err_dup}, 0);
        @(negedge clk);
        rst = 1'b0;

        // list 1,5,3,10
        send(1, 0); send(5, 0); send(3, 0); send(10, 1);
        repeat (3) idle();

        // single node 6: no write after the accept edge, terminating write one cycle later
        send(6, 1);
        idle();
        check("t2_no_early_wr", bus.wr_en, 0);
        idle();
        check("t2_term_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, W'(6), W'(0)});
        repeat (3) idle();

        // FIFO full blocks the fifth list until one head is popped
        idle(1'b1);
        hr = 1'b0;
        send(11, 1); send(12, 1); send(13, 1); send(14, 1);
        repeat (2) idle();
        cycle(1'b1, 2, 1'b1, 1'b0, acc);
        check("t3_blocked", acc, 0);
        hr = 1'b1;
        send(2, 1);
        repeat (8) idle();

        // duplicate rejection, then clear and reuse
        idle(1'b1);
        send(7, 0); send(15, 1);
        repeat (2) idle();
        send(7, 0);
        idle();
        check("t4_dup_pulse", bus.err_dup, 1);
        idle(1'b1);
        send(7, 1);
        repeat (3) idle();

        // null node closing an open list
        send(9, 0); send(0, 1);
        idle();
        check("t5_null_pulse", bus.err_null, 1);
        repeat (3) idle();

        // reset in the middle of an open list
        send(2, 0); send(4, 0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.head_vld,
                                 bus.head_ptr, bus.err_null, bus.err_dup, bus.in_rdy}, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) idle();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            hr = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, N - 1),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, acc);
        end

        hr = 1'b1;
        send(0, 1);
        repeat (12) idle();
        check("drain_writes", wq.size(), 0);
        check("drain_heads", hq.size(), 0);
        check("drain_errs", eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
